// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester cache port arbiter.
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEFAULT_ACCESS_CYCLES = 4;
    localparam int DEFAULT_ADDR_WIDTH    = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    // Down-counter width; a single-cycle access still needs a 1-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_select2.sv
// Two-way round-robin pick: on a tie the requester not granted last time wins.
module rr_select2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin front end that serialises two requesters onto one cache_and_ram port,
// holding each access for ACCESS_CYCLES clocks and returning a one-cycle ack.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_mode,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    // Handshake: reqN acts as valid and stays high with weN/addrN/wdataN stable
    // until ackN; ackN is a one-cycle completion pulse (there is no separate ready).
    // A req still high in the cycle after ack is a fresh request.

    localparam int CNT_W = cnt_width(ACCESS_CYCLES);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             grant_id;
    logic             last_grant;
    logic             sel_valid;
    logic             sel_winner;
    logic             start;
    logic             finish;

    rr_select2 u_rr_select2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (sel_valid),
        .winner     (sel_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    next_state = ACCESS;
                    start      = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    next_state = RESP;
                    finish     = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            mem_address <= '0;
            mem_data    <= '0;
            mem_mode    <= MODE_READ;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            ack0 <= finish & ~grant_id;
            ack1 <= finish & grant_id;
            if (start) begin
                grant_id    <= sel_winner;
                last_grant  <= sel_winner;
                cnt         <= CNT_W'(ACCESS_CYCLES - 1);
                mem_address <= sel_winner ? addr1  : addr0;
                mem_data    <= sel_winner ? wdata1 : wdata0;
                mem_mode    <= sel_winner ? we1    : we0;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // mem_mode still carries the latched access type on the finishing edge.
            if (finish) begin
                mem_mode <= MODE_READ;
                if (mem_mode == MODE_READ) begin
                    if (grant_id) rdata1 <= mem_out;
                    else          rdata0 <= mem_out;
                end
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a behavioural cache_and_ram stand-in.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, ack1, mem_mode, busy;
    logic [31:0] rdata0, rdata1, mem_address, mem_data;
    logic [31:0] mem_out = '0;
    logic [1:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_HI = 32'd2816867292;
    localparam logic [31:0] A_LO = 32'd1001425;
    localparam logic [31:0] D_HI = 32'd526421;
    localparam logic [31:0] D_LO = 32'd25369366;
    localparam logic [31:0] D_W  = 32'd14528;

    always #5 clk = ~clk;

    cache_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode),
        .mem_out(mem_out), .busy(busy), .fsm_state(fsm_state)
    );

    // Stand-in for cache_and_ram: writes on the edge, read data settles mid-cycle.
    logic [31:0] mem_model [logic [31:0]];
    always @(posedge clk) if (mem_mode) mem_model[mem_address] = mem_data;
    always @(negedge clk) mem_out = mem_model.exists(mem_address) ? mem_model[mem_address] : 32'd0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (all driving happens at negedge) ----------------
    task automatic wait_ack(input int id, output int lat, output int mode_hi, output bit timed_out);
        lat = 0; mode_hi = 0; timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mem_mode) mode_hi++;
            if ((id == 0 && ack0) || (id == 1 && ack1)) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic single(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int mode_hi,
                          output bit timed_out);
        if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        else         begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        wait_ack(id, lat, mode_hi, timed_out);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_pair(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            output int t0, output int t1, output logic [31:0] r0,
                            output logic [31:0] r1, output bit timed_out);
        req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1;
        t0 = -1; t1 = -1; r0 = '0; r1 = '0; timed_out = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack0) begin t0 = i; r0 = rdata0; req0 = 1'b0; end
            if (ack1) begin t1 = i; r1 = rdata1; req1 = 1'b0; end
            if (t0 >= 0 && t1 >= 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ack0, ack1, mem_mode, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {ack0, ack1, mem_mode, busy});
        end
        n_tests++;
        if ({rdata0, rdata1, mem_address, mem_data} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0", rdata0, rdata1, mem_address, mem_data);
        end
        n_tests++;
        if (fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, mh;
        bit to;
        single(0, 1'b1, 32'd0, D_W, lat, mh, to);
        n_tests++;
        if (to || lat != 5) begin n_fail++; $display("FAIL wr_latency: got %0d (timeout %0d) want 5", lat, to); end
        n_tests++;
        if (mh != 4) begin n_fail++; $display("FAIL wr_mode_cycles: got %0d want 4", mh); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_between: got %b want 0", busy); end
        single(1, 1'b0, 32'd0, 32'd0, lat, mh, to);
        n_tests++;
        if (to || mh != 0 || rdata1 !== D_W) begin
            n_fail++; $display("FAIL rd_after_wr: got %0d mode_hi %0d timeout %0d want %0d", rdata1, mh, to, D_W);
        end
    endtask

    task automatic test_simultaneous();
        int t0, t1, lat, mh;
        logic [31:0] r0, r1;
        bit to;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_pair(1'b1, A_HI, D_HI, 1'b1, A_LO, D_LO, t0, t1, r0, r1, to);
        n_tests++;
        if (to || t0 != 5 || t1 != 11) begin
            n_fail++; $display("FAIL sim_order: got t0=%0d t1=%0d timeout %0d want 5 11", t0, t1, to);
        end
        single(1, 1'b0, A_HI, 32'd0, lat, mh, to);
        n_tests++;
        if (to || rdata1 !== D_HI) begin n_fail++; $display("FAIL readback1: got %0d want %0d", rdata1, D_HI); end
        single(0, 1'b0, A_LO, 32'd0, lat, mh, to);
        n_tests++;
        if (to || rdata0 !== D_LO) begin n_fail++; $display("FAIL readback0: got %0d want %0d", rdata0, D_LO); end
    endtask

    task automatic test_alternation();
        int t0, t1, lat, mh;
        logic [31:0] r0, r1;
        bit to;
        // last grant was requester 0, so requester 1 takes the tie
        run_pair(1'b0, A_HI, 32'd0, 1'b0, A_LO, 32'd0, t0, t1, r0, r1, to);
        n_tests++;
        if (to || t1 != 5 || t0 != 11) begin
            n_fail++; $display("FAIL alt_pair2: got t0=%0d t1=%0d want 11 5", t0, t1);
        end
        n_tests++;
        if (r0 !== D_HI || r1 !== D_LO) begin
            n_fail++; $display("FAIL alt_pair2_data: got %0d %0d want %0d %0d", r0, r1, D_HI, D_LO);
        end
        single(1, 1'b0, A_LO, 32'd0, lat, mh, to);
        run_pair(1'b0, A_LO, 32'd0, 1'b0, A_HI, 32'd0, t0, t1, r0, r1, to);
        n_tests++;
        if (to || t0 != 5 || t1 != 11) begin
            n_fail++; $display("FAIL alt_pair3: got t0=%0d t1=%0d want 5 11", t0, t1);
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int ack0_samples;
        int exp_order[5] = '{0, 1, 0, 1, 0};
        bit prev0;
        ack0_samples = 0; prev0 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = A_LO;
        req1 = 1'b1; we1 = 1'b0; addr1 = A_HI;
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            @(negedge clk);
            if (ack0) begin
                ack0_samples++;
                if (!prev0) order.push_back(0);
                n_tests++;
                if (rdata0 !== D_LO) begin n_fail++; $display("FAIL b2b_rdata0: got %0d want %0d", rdata0, D_LO); end
            end
            if (ack1) begin
                order.push_back(1);
                n_tests++;
                if (rdata1 !== D_HI) begin n_fail++; $display("FAIL b2b_rdata1: got %0d want %0d", rdata1, D_HI); end
            end
            prev0 = ack0;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        n_tests++;
        if (order.size() != 5) begin
            n_fail++; $display("FAIL b2b_count: got %0d grants want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (order[i] != exp_order[i]) begin
                    n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
                end
            end
        end
        n_tests++;
        if (ack0_samples != 3) begin n_fail++; $display("FAIL ack0_pulse: got %0d high cycles want 3", ack0_samples); end
    endtask

    task automatic test_reset_abort();
        int lat, mh;
        bit to;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3036; wdata0 = D_W;
        repeat (2) @(negedge clk);
        n_tests++;
        if (mem_mode !== 1'b1) begin n_fail++; $display("FAIL abort_pre_mode: got %b want 1", mem_mode); end
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_mode, ack0, busy} !== 3'b000 || fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL abort_outs: got mode/ack/busy %b state %0d want 000 0", {mem_mode, ack0, busy}, fsm_state);
        end
        reset = 1'b0;
        @(negedge clk);
        single(0, 1'b1, 32'd3036, D_W, lat, mh, to);
        single(0, 1'b0, 32'd3036, 32'd0, lat, mh, to);
        n_tests++;
        if (to || rdata0 !== D_W) begin n_fail++; $display("FAIL abort_reissue: got %0d want %0d", rdata0, D_W); end
    endtask

    task automatic test_input_toggle();
        bit saw_ack1, to;
        saw_ack1 = 1'b0; to = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = A_LO;
        @(negedge clk);
        addr0 = 32'd0; we0 = 1'b1; wdata0 = 32'd99;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd555;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req1 = 1'b0;
            if (ack1) saw_ack1 = 1'b1;
            n_tests++;
            if (mem_address !== A_LO || mem_mode !== 1'b0) begin
                n_fail++; $display("FAIL toggle_latched: got addr %0d mode %b want %0d 0", mem_address, mem_mode, A_LO);
            end
            if (ack0) begin to = 1'b0; break; end
        end
        n_tests++;
        if (to || rdata0 !== D_LO) begin n_fail++; $display("FAIL toggle_rdata: got %0d want %0d", rdata0, D_LO); end
        req0 = 1'b0; we0 = 1'b0;
        repeat (2) @(negedge clk);
        if (ack1) saw_ack1 = 1'b1;
        n_tests++;
        if (saw_ack1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL toggle_no_grant1: got ack1 seen %b busy %b want 0 0", saw_ack1, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_alternation();
        test_back_to_back();
        test_reset_abort();
        test_input_toggle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Two-requester front end for the cache_and_ram block. It arbitrates between two requesters with round-robin priority. It drives cache_and_ram's address/data/mode inputs and holds them stable for a fixed number of clocks per access. It then captures the read result and returns a one-cycle acknowledge to the winning requester.

Parameters:
ADDR_WIDTH, 32, width of the address bus (cache_and_ram address).
DATA_WIDTH, 32, width of the write data and read data buses.
ACCESS_CYCLES, 4, clocks the request is held on the memory side per access (must be >= 1).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; held high until ack0
we0  input  1  requester 0 mode: 1 = write, 0 = read
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  DATA_WIDTH  read result for requester 0; valid while ack0 is high
req1, we1, addr1, wdata1, ack1, rdata1  same as above for requester 1
mem_address  output  ADDR_WIDTH  to cache_and_ram address
mem_data  output  DATA_WIDTH  to cache_and_ram data
mem_mode  output  1  to cache_and_ram mode (1 = write)
mem_out  input  DATA_WIDTH  from cache_and_ram out
busy  output  1  high in every state except IDLE

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state = IDLE; ack0 = ack1 = 0; rdata0 = rdata1 = 0; mem_address = 0; mem_data = 0; mem_mode = 0; busy = 0; last_grant = 1, so requester 0 wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE -> ACCESS:
  - Taken at edge k if req0 or req1 is high.
  - Winner: the only requester asking, or, if both ask, the one not equal to last_grant.
  - At that edge: register the winner's addr, wdata and we into mem_address, mem_data and mem_mode; set grant id and last_grant = winner; set cnt = ACCESS_CYCLES-1.
- ACCESS:
  - mem_* held constant.
  - Each edge with cnt != 0 decrements cnt.
  - At the edge with cnt == 0 (edge k+ACCESS_CYCLES):
    - if the access is a read, capture mem_out into rdata of the winner;
    - drive mem_mode to 0;
    - set ack of the winner to 1;
    - go to RESP.
- RESP:
  - ack is high for exactly this one cycle.
  - At the next edge, ack returns to 0 and state returns to IDLE.
  - rdata holds its value until the next read by the same requester.
- Latency: req sampled at edge k -> ack high in the cycle after edge k+ACCESS_CYCLES. Minimum spacing between grants is ACCESS_CYCLES+2 edges.
- Writes: mem_mode is high for exactly ACCESS_CYCLES cycles and low in IDLE/RESP. A write leaves rdata of that requester unchanged.
- mem_address and mem_data are not cleared after an access; they hold their last value.
- Handshake:
  - The requester keeps req, we, addr and wdata stable from assertion until it sees ack.
  - req still high in the cycle after ack is treated as a new request.
  - Input changes during ACCESS are ignored, because the request is latched.
- Losing requester: it keeps req high and is served next; round-robin guarantees service within one access.
- Simultaneous req and reset: reset wins; no grant.
- Reset mid-ACCESS or mid-RESP:
  - abort; all outputs go to reset values at that edge, so mem_mode drops and no ack is issued;
  - the memory contents at the aborted address are undefined and the requester must reissue.
- Addresses pass through unmodified; index wrap-around is cache_and_ram's concern.

Decomposition:
- Shared package: state encoding (IDLE, ACCESS, RESP); MODE_READ = 0 and MODE_WRITE = 1; default ACCESS_CYCLES = 4; default widths of 32.
- One sub-module: rr_select2, a two-way round-robin pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: valid, winner.
  - Purely combinational; the last_grant register stays in the parent.

Test Plan:
- Requester 0 writes 14528 to address 0, then requester 1 reads address 0.
  - Required: ack0 after 4 cycles with mem_mode high for exactly those 4 cycles.
  - Required: rdata1 = 14528 with ack1.
  - Required: busy low between accesses.
- Requester 0 writes 526421 to address 2816867292; requester 1 writes 25369366 to address 1001425; both are raised on the same edge right after reset.
  - Required: requester 0 granted first and requester 1 granted 6 edges later.
  - Read-back of each address from either requester returns 526421 and 25369366.
- Both requesters are raised simultaneously again.
  - Required: requester 1 now wins (alternation).
  - Required: a third simultaneous pair is won by requester 0.
- Requester 0 holds req high continuously across 3 reads of address 1001425 while requester 1 also requests.
  - Required: grants alternate 0,1,0,1.
  - Required: each ack0 is a single-cycle pulse.
- Reset is asserted 2 cycles into a write of 14528 to address 3036.
  - Required: mem_mode = 0 and ack0 = 0 at the next edge, and the state is IDLE.
  - A reissued write followed by a read returns 14528.
- Req inputs toggle during ACCESS (addr0 changes mid-access).
  - Required: mem_address stays at the latched value until RESP.
